hit_judge_sequencer: RTL
========================

Name: hit_judge_sequencer

Overview:
Parametrised hit-judging and sound-sequencing core for the whack-a-box game. It takes a target box from the LFSR or level-select path and a raw strike code from the Arduino sensor GPIO. It debounces strikes, judges each round within a timed window, and keeps a saturating score. It also drives the ROM address for the hit or miss sound clip played through the audio controller.

Parameters:
NUM_BOXES, 8, box codes 1..NUM_BOXES-1 are valid; code 0 means "no strike / lobby"
BOX_W, 3, width of box codes (2^BOX_W >= NUM_BOXES)
SCORE_W, 11, score width
HIT_PTS, 1, points added on hit
MISS_PTS, 1, points subtracted on miss or timeout
DEBOUNCE, 4, cycles a nonzero sensor code must be stable to count as a strike (>=1)
HIT_WINDOW, 50000000, cycles allowed per round after the target is armed
SAMPLE_DIV, 2400, clock cycles per ROM sample
CLIP_LEN, 16396, samples per clip
ROM_AW, 18, ROM address width

Ports:
CLOCK_50  in  1  system clock
resetn  in  1  asynchronous active-low reset
start  in  1  pulse; in IDLE, clears the score and begins the game
stop  in  1  pulse; returns to IDLE from any state
target_valid  in  1  pulse; presents a new target
target_box  in  BOX_W  target code, sampled when target_valid=1
sensor_box  in  BOX_W  raw strike code from GPIO
score  out  SCORE_W  current score
hit_pulse  out  1  one-cycle pulse on a correct strike
miss_pulse  out  1  one-cycle pulse on a wrong strike or timeout
round_active  out  1  high in ARMED
sound_active  out  1  clip playing
sound_sel  out  1  0 = hit clip, 1 = miss clip
rom_addr  out  ROM_AW  sample address

Behaviour:
- Reset values: score=0, hit_pulse=0, miss_pulse=0, round_active=0, sound_active=0, sound_sel=0, rom_addr=0. FSM=IDLE. All counters are 0.
- Debouncer:
  - A stability counter restarts whenever sensor_box changes.
  - When the code is nonzero and the counter reaches DEBOUNCE-1, a one-cycle strike event fires carrying the code.
  - Only one strike fires per press. sensor_box must return to 0 for at least 1 cycle before the next strike can fire.
  - The debouncer runs in all states. Strikes outside ARMED are discarded.
- FSM states: IDLE, WAIT_TGT, ARMED, JUDGE.
  - IDLE: start -> score<=0, go to WAIT_TGT.
  - WAIT_TGT:
    - target_valid with target_box in 1..NUM_BOXES-1 -> latch the target, load window=HIT_WINDOW-1, go to ARMED.
    - An invalid target code is ignored.
  - ARMED:
    - The window decrements each cycle.
    - A strike equal to the target -> hit. A strike not equal to the target -> miss. Window==0 with no strike -> miss (timeout).
    - A strike and window==0 in the same cycle: the strike is judged and the timeout is ignored.
    - target_valid is ignored in ARMED.
  - JUDGE (1 cycle):
    - Issues hit_pulse or miss_pulse and updates score.
    - Registered, so the pulse and new score appear 1 cycle after the deciding event.
    - Next state is WAIT_TGT.
  - stop in any state -> IDLE next cycle. Score is held; no pulse is issued. If stop coincides with a deciding event, stop wins.
- Score arithmetic:
  - Hit: score = min(score+HIT_PTS, 2^SCORE_W-1).
  - Miss: score = max(score-MISS_PTS, 0).
  - The intermediate is computed at SCORE_W+1 bits so it never wraps.
- Sound sequencer (independent of the FSM):
  - On hit_pulse or miss_pulse: sound_active<=1, sound_sel<=miss, rom_addr<=0, divider<=0.
  - A new pulse mid-clip restarts the clip from 0 with the new sound_sel.
  - While active, rom_addr increments when the divider reaches SAMPLE_DIV-1; the divider then wraps to 0.
  - After address CLIP_LEN-1 has been held for a full SAMPLE_DIV period: sound_active<=0, rom_addr<=0.
  - When idle, rom_addr is held at 0.
- Asynchronous reset mid-round or mid-clip returns everything to reset values immediately. No pulse is issued.

Test Plan:
1. Reset, start, target_valid with target_box=3, sensor_box=3 held 4 cycles (DEBOUNCE=4) -> strike on cycle 4, hit_pulse 1 cycle later, score 0->1, sound_active=1, sound_sel=0, rom_addr 0 then 1 after 2400 cycles.
2. Target 5, sensor glitches 5 for 2 cycles then 0 -> no strike; HIT_WINDOW=100 expires -> miss_pulse at cycle 101, score stays 0 (floor), sound_sel=1.
3. Score preloaded to 2047 via hits with SCORE_W=11, one more hit -> score stays 2047. Sensor 3 held 20 cycles -> exactly one strike.
4. Wrong strike (target 2, sensor 6) -> miss_pulse, score 10->9. Strike coinciding with window==0 -> judged as a strike, with a single pulse.
5. Hit, then miss 500 cycles into the clip -> rom_addr restarts at 0 with sound_sel=1. Full clip with SAMPLE_DIV=4, CLIP_LEN=8 -> sound_active drops after 32 cycles.
6. stop asserted in ARMED, or resetn pulled low mid-clip -> IDLE with no pulse. Reset case: all outputs at reset values within the same cycle.

Source files
------------

// File: rtl/hit_judge_sequencer_if.sv
// Bus between the game controller / sensor GPIO side and the hit judge core.
// The master side drives strikes and targets; the slave side (the core) returns score and sound.
interface hit_judge_sequencer_if #(
   parameter int unsigned BOX_W   = 3,
   parameter int unsigned SCORE_W = 11,
   parameter int unsigned ROM_AW  = 18
);
   logic               start;
   logic               stop;
   logic               target_valid;
   logic [BOX_W-1:0]   target_box;
   logic [BOX_W-1:0]   sensor_box;
   logic [SCORE_W-1:0] score;
   logic               hit_pulse;
   logic               miss_pulse;
   logic               round_active;
   logic               sound_active;
   logic               sound_sel;
   logic [ROM_AW-1:0]  rom_addr;

   modport master (
      output start, stop, target_valid, target_box, sensor_box,
      input  score, hit_pulse, miss_pulse, round_active, sound_active, sound_sel, rom_addr
   );

   modport slave (
      input  start, stop, target_valid, target_box, sensor_box,
      output score, hit_pulse, miss_pulse, round_active, sound_active, sound_sel, rom_addr
   );
endinterface

// File: rtl/hit_judge_sequencer.sv
// Whack-a-box core: debounces sensor strikes, judges timed rounds against the target,
// keeps a saturating score and sequences the hit/miss sound clip ROM address.
module hit_judge_sequencer #(
   parameter int unsigned NUM_BOXES  = 8,
   parameter int unsigned BOX_W      = 3,
   parameter int unsigned SCORE_W    = 11,
   parameter int unsigned HIT_PTS    = 1,
   parameter int unsigned MISS_PTS   = 1,
   parameter int unsigned DEBOUNCE   = 4,
   parameter int unsigned HIT_WINDOW = 50000000,
   parameter int unsigned SAMPLE_DIV = 2400,
   parameter int unsigned CLIP_LEN   = 16396,
   parameter int unsigned ROM_AW     = 18
) (
   input logic                  CLOCK_50,
   input logic                  resetn,
   hit_judge_sequencer_if.slave io
);

   localparam int unsigned DB_W  = (DEBOUNCE > 1)   ? $clog2(DEBOUNCE)   : 1;
   localparam int unsigned WIN_W = (HIT_WINDOW > 1) ? $clog2(HIT_WINDOW) : 1;
   localparam int unsigned DIV_W = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
   localparam int unsigned SW1   = SCORE_W + 1;

   localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DEBOUNCE - 1);
   localparam logic [WIN_W-1:0]  WIN_LOAD  = WIN_W'(HIT_WINDOW - 1);
   localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(SAMPLE_DIV - 1);
   localparam logic [ROM_AW-1:0] ADDR_LAST = ROM_AW'(CLIP_LEN - 1);
   localparam logic [SW1-1:0]    SCORE_MAX = {1'b0, {SCORE_W{1'b1}}};
   localparam logic [SW1-1:0]    HIT_INC   = SW1'(HIT_PTS);
   localparam logic [SW1-1:0]    MISS_DEC  = SW1'(MISS_PTS);

   typedef enum logic [1:0] {
      S_IDLE,
      S_WAIT_TGT,
      S_ARMED,
      S_JUDGE
   } state_t;

   state_t state, state_nx;

   // ---------------- debouncer ----------------
   logic [BOX_W-1:0] db_prev;
   logic [DB_W-1:0]  db_cnt;
   logic             db_fired;
   logic             strike;

   // db_fired blocks re-triggering until the sensor has read 0 for a cycle
   assign strike = (db_prev != '0) && (db_cnt == DB_LAST) && !db_fired;

   always_ff @(posedge CLOCK_50 or negedge resetn) begin
      if (!resetn) begin
         db_prev  <= '0;
         db_cnt   <= '0;
         db_fired <= 1'b0;
      end else begin
         db_prev <= io.sensor_box;
         if (io.sensor_box != db_prev)
            db_cnt <= '0;
         else if (db_cnt != DB_LAST)
            db_cnt <= db_cnt + 1'b1;
         if (db_prev == '0)
            db_fired <= 1'b0;
         else if (strike)
            db_fired <= 1'b1;
      end
   end

   // ---------------- round FSM ----------------
   logic [BOX_W-1:0]   tgt;
   logic [WIN_W-1:0]   window;
   logic [SCORE_W-1:0] score_q;
   logic               hit_q, miss_q;
   logic               tgt_ok;
   logic               clr_score, arm, win_dec, dec_hit, dec_miss;

   assign tgt_ok = (io.target_box != '0) && (32'(io.target_box) < NUM_BOXES);

   always_comb begin
      state_nx  = state;
      clr_score = 1'b0;
      arm       = 1'b0;
      win_dec   = 1'b0;
      dec_hit   = 1'b0;
      dec_miss  = 1'b0;
      if (io.stop) begin
         state_nx = S_IDLE;
      end else begin
         case (state)
            S_IDLE: begin
               if (io.start) begin
                  clr_score = 1'b1;
                  state_nx  = S_WAIT_TGT;
               end
            end
            S_WAIT_TGT: begin
               if (io.target_valid && tgt_ok) begin
                  arm      = 1'b1;
                  state_nx = S_ARMED;
               end
            end
            S_ARMED: begin
               // a strike landing on the last window cycle outranks the timeout
               if (strike) begin
                  dec_hit  = (db_prev == tgt);
                  dec_miss = (db_prev != tgt);
                  state_nx = S_JUDGE;
               end else if (window == '0) begin
                  dec_miss = 1'b1;
                  state_nx = S_JUDGE;
               end else begin
                  win_dec = 1'b1;
               end
            end
            S_JUDGE: state_nx = S_WAIT_TGT;
            default: state_nx = S_IDLE;
         endcase
      end
   end

   logic [SW1-1:0]     score_ext, hit_sum;
   logic [SCORE_W-1:0] score_hit, score_miss;

   always_comb begin
      score_ext  = {1'b0, score_q};
      hit_sum    = score_ext + HIT_INC;
      score_hit  = (hit_sum > SCORE_MAX) ? '1 : hit_sum[SCORE_W-1:0];
      score_miss = '0;
      if (score_ext >= MISS_DEC)
         score_miss = score_q - MISS_DEC[SCORE_W-1:0];
   end

   always_ff @(posedge CLOCK_50 or negedge resetn) begin
      if (!resetn) begin
         state   <= S_IDLE;
         tgt     <= '0;
         window  <= '0;
         score_q <= '0;
         hit_q   <= 1'b0;
         miss_q  <= 1'b0;
      end else begin
         state  <= state_nx;
         hit_q  <= dec_hit;
         miss_q <= dec_miss;
         if (arm) begin
            tgt    <= io.target_box;
            window <= WIN_LOAD;
         end else if (win_dec) begin
            window <= window - 1'b1;
         end
         if (clr_score)
            score_q <= '0;
         else if (dec_hit)
            score_q <= score_hit;
         else if (dec_miss)
            score_q <= score_miss;
      end
   end

   // ---------------- sound sequencer ----------------
   logic              snd_active, snd_sel;
   logic [ROM_AW-1:0] addr;
   logic [DIV_W-1:0]  div;

   always_ff @(posedge CLOCK_50 or negedge resetn) begin
      if (!resetn) begin
         snd_active <= 1'b0;
         snd_sel    <= 1'b0;
         addr       <= '0;
         div        <= '0;
      end else if (hit_q || miss_q) begin
         snd_active <= 1'b1;
         snd_sel    <= miss_q;
         addr       <= '0;
         div        <= '0;
      end else if (snd_active) begin
         if (div == DIV_LAST) begin
            div <= '0;
            if (addr == ADDR_LAST) begin
               snd_active <= 1'b0;
               addr       <= '0;
            end else begin
               addr <= addr + 1'b1;
            end
         end else begin
            div <= div + 1'b1;
         end
      end
   end

   assign io.score        = score_q;
   assign io.hit_pulse    = hit_q;
   assign io.miss_pulse   = miss_q;
   assign io.round_active = (state == S_ARMED);
   assign io.sound_active = snd_active;
   assign io.sound_sel    = snd_sel;
   assign io.rom_addr     = addr;

endmodule
